// File: rtl/feedback_pkg.sv
// Shared types and helpers for feedback_pulse_generator.
package feedback_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } fb_state_t;

  function automatic logic [31:0] ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator for passive piezo drive; output is registered,
// restarts high on clear and is forced low while disabled.
module tone_divider #(
  parameter int unsigned HALF_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tone
);

  localparam logic [31:0] HALF_LAST = HALF_CYCLES - 32'd1;

  logic [31:0] half_cnt;

  if (HALF_CYCLES == 0) begin : g_bad_half
    $error("tone_divider: HALF_CYCLES must be >= 1");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_cnt <= '0;
      tone     <= 1'b0;
    end else if (clear) begin
      half_cnt <= '0;
      tone     <= 1'b1;
    end else if (enable) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        tone     <= ~tone;
      end else begin
        half_cnt <= half_cnt + 32'd1;
      end
    end else begin
      half_cnt <= '0;
      tone     <= 1'b0;
    end
  end

endmodule

// File: rtl/feedback_pulse_generator.sv
// Stretches event strobes into fixed ON/GAP pulses with a saturating replay queue.
// Define FEEDBACK_TONE_EN to drive a square-wave tone during ON instead of a level.
module feedback_pulse_generator
  import feedback_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 40_000_000,
  parameter int unsigned ON_TIME_MS  = 100,
  parameter int unsigned GAP_TIME_MS = 100,
  parameter int unsigned PEND_W      = 3,
  parameter int unsigned TONE_HZ     = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_pulse,
  input  logic              clr_overflow,
  output logic              beep_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [31:0] ON_LAST  = ms_to_cycles(CLK_FREQ, ON_TIME_MS) - 32'd1;
  localparam logic [31:0] GAP_LAST = ms_to_cycles(CLK_FREQ, GAP_TIME_MS) - 32'd1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  if (ON_TIME_MS == 0 || GAP_TIME_MS == 0 || TONE_HZ == 0) begin : g_bad_params
    $error("feedback_pulse_generator: ON_TIME_MS, GAP_TIME_MS and TONE_HZ must be >= 1");
  end

  fb_state_t         state, state_next;
  logic [31:0]       cnt, cnt_next;
  logic [PEND_W-1:0] pend_next;
  logic              dec;
  logic              ovf_set;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 32'd1;
    dec        = 1'b0;
    pend_next  = pending;
    ovf_set    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (event_pulse) state_next = ON;
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_next = '0;
          if (pending != '0 || event_pulse) begin
            state_next = ON;
            dec        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // An event coinciding with a replay cancels out, which also covers the
    // GAP-end event with an empty queue being consumed directly.
    if (state != IDLE) begin
      if (event_pulse && !dec) begin
        if (pending == PEND_MAX) ovf_set = 1'b1;
        else                     pend_next = pending + PEND_W'(1);
      end else if (!event_pulse && dec) begin
        pend_next = pending - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      pending  <= pend_next;
      overflow <= ovf_set | (overflow & ~clr_overflow);
      busy     <= (state_next != IDLE);
    end
  end

`ifdef FEEDBACK_TONE_EN
  localparam int unsigned HALF_CYCLES = CLK_FREQ / (2 * TONE_HZ);

  tone_divider #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_tone (
    .clk   (clk),
    .reset (reset),
    .enable(state_next == ON),
    .clear (state_next == ON && state != ON),
    .tone  (beep_out)
  );
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) beep_out <= 1'b0;
    else        beep_out <= (state_next == ON);
  end
`endif

endmodule

// File: tb/tb_feedback_pulse_generator.sv
// Directed bench for feedback_pulse_generator at ON_CYCLES=5, GAP_CYCLES=3, PEND_W=2.
module tb_feedback_pulse_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       event_pulse = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       beep_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  feedback_pulse_generator #(
    .CLK_FREQ   (1000),
    .ON_TIME_MS (5),
    .GAP_TIME_MS(3),
    .PEND_W     (2),
    .TONE_HZ    (250)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .event_pulse (event_pulse),
    .clr_overflow(clr_overflow),
    .beep_out    (beep_out),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected beep_out at position k (0..7) within an ON+GAP period.
  function automatic logic beep_at(input int k);
`ifdef FEEDBACK_TONE_EN
    return (k < 5) && (((k / 2) % 2) == 0);
`else
    return k < 5;
`endif
  endfunction

  // Hold inputs for one clock, then return 1ns after the sampling edge.
  task automatic cyc(input logic ev, input logic clr);
    event_pulse  = ev;
    clr_overflow = clr;
    @(posedge clk);
    #1;
    event_pulse  = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    event_pulse = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b0;
    event_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {beep_out, busy, pending, overflow};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", got, 5'b0);
    end
    event_pulse = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] got, exp;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(i == 0, 1'b0);
      exp = {(i < 8) ? beep_at(i) : 1'b0, i < 8, 2'd0};
      got = {beep_out, busy, pending};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single step %0d got %b exp %b", i, got, exp);
      end
    end
  endtask

  task automatic test_queue();
    logic [3:0] got, exp;
    logic [1:0] pe;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      cyc(i == 0 || i == 2 || i == 3, 1'b0);
      if (i < 2)       pe = 2'd0;
      else if (i == 2) pe = 2'd1;
      else if (i < 8)  pe = 2'd2;
      else if (i < 16) pe = 2'd1;
      else             pe = 2'd0;
      exp = {(i < 24) ? beep_at(i % 8) : 1'b0, i < 24, pe};
      got = {beep_out, busy, pending};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL queue step %0d got %b exp %b", i, got, exp);
      end
    end
  endtask

  task automatic test_saturate();
    logic [4:0] got, exp;
    logic [1:0] pe;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      cyc(i <= 5, i == 5 || i == 6);
      if (i < 3)       pe = 2'(i);
      else if (i < 8)  pe = 2'd3;
      else if (i < 16) pe = 2'd2;
      else if (i < 24) pe = 2'd1;
      else             pe = 2'd0;
      exp = {(i < 32) ? beep_at(i % 8) : 1'b0, i < 32, pe, (i == 4 || i == 5)};
      got = {beep_out, busy, pending, overflow};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL saturate step %0d got %b exp %b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cyc(i == 0 || i == 8, 1'b0);
      exp = {(i < 16) ? beep_at(i % 8) : 1'b0, i < 16, 2'd0};
      got = {beep_out, busy, pending};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gap_end_event step %0d got %b exp %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got, exp;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    exp = {beep_at(4), 1'b1, 2'd3, 1'b1};
    got = {beep_out, busy, pending, overflow};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pre_reset_load got %b exp %b", got, exp);
    end
    #2;
    reset = 1'b0;
    #1;
    got = {beep_out, busy, pending, overflow};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", got, 5'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      got = {beep_out, busy, pending, overflow};
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL no_replay step %0d got %b exp %b", i, got, 5'b0);
      end
    end
  endtask

`ifdef FEEDBACK_TONE_EN
  task automatic test_tone();
    logic [15:0] got, exp;
    do_reset();
    got = '0;
    for (int i = 0; i < 16; i++) begin
      cyc(i == 0 || i == 1, 1'b0);
      got[i] = beep_out;
    end
    // Two pulses, each ON phase 1,1,0,0,1 then GAP 0,0,0 (LSB = first cycle).
    exp = 16'b00010011_00010011;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL tone_pattern got %b exp %b", got, exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
`ifdef FEEDBACK_TONE_EN
    test_tone();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
